// File: rtl/jtag_dr_pkg.sv
// DR geometry helpers: total width and capture-word status bit positions.
package jtag_dr_pkg;

  function automatic int dr_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Capture word: DR[DATA_W-1:0] = tx word (or 0), then rx_full, then tx_full.
  function automatic int st_rx_full(input int data_w);
    return data_w;
  endfunction

  function automatic int st_tx_full(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/jtag_dr_sync.sv
// TAP signal synchroniser with a registered rising-edge pulse; rise appears STAGES+1 clk after the pin.
module jtag_dr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      hist  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      hist  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~hist;
    end
  end

endmodule

// File: rtl/jtag_dr_engine.sv
// Oversampled JTAG DR engine with rx/tx holding registers; update pin -> rx_valid_o in SYNC_STAGES+2 clk.
// JTAG_DR_OVERRUN_CNT_EN adds overrun_cnt_o, a saturating count of dropped updates.
module jtag_dr_engine
  import jtag_dr_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              jtag_tck_i,
  input  logic              jtag_tdi_i,
  output logic              jtag_tdo_o,
  input  logic              jtag_capture_i,
  input  logic              jtag_shift_i,
  input  logic              jtag_update_i,
  input  logic              jtag_reset_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic [ADDR_W-1:0] rx_addr_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              overrun_o
`ifdef JTAG_DR_OVERRUN_CNT_EN
  , output logic [7:0]      overrun_cnt_o
`endif
);

  localparam int W   = dr_width(ADDR_W, DATA_W);
  localparam int RXF = st_rx_full(DATA_W);
  localparam int TXF = st_tx_full(DATA_W);

  logic                           tck_rise, upd_rise;
  logic [SYNC_STAGES:0][3:0]      lvl;
  logic                           s_tdi, s_cap, s_shift, s_reset;
  logic [W-1:0]                   sr, cap_word;
  logic [DATA_W-1:0]              tx_hold;
  logic                           tx_full;
  logic                           cap_fire, tx_push, rx_load, rx_drop;

  jtag_dr_sync #(.STAGES(SYNC_STAGES)) u_sync_tck (
    .clk (clk_i), .rst (rst_i), .d (jtag_tck_i), .rise (tck_rise)
  );

  jtag_dr_sync #(.STAGES(SYNC_STAGES)) u_sync_upd (
    .clk (clk_i), .rst (rst_i), .d (jtag_update_i), .rise (upd_rise)
  );

  // One stage deeper than the bare synchroniser so levels line up with the registered rise pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl <= '0;
    end else begin
      lvl <= {lvl[SYNC_STAGES-1:0], {jtag_tdi_i, jtag_capture_i, jtag_shift_i, jtag_reset_i}};
    end
  end

  assign {s_tdi, s_cap, s_shift, s_reset} = lvl[SYNC_STAGES];

  always_comb begin
    cap_word      = '0;
    cap_word[RXF] = rx_valid_o;
    cap_word[TXF] = tx_full;
    if (tx_full) begin
      cap_word[DATA_W-1:0] = tx_hold;
    end
  end

  assign cap_fire   = tck_rise & s_cap & ~s_reset;
  assign tx_push    = tx_valid_i & ~tx_full;
  assign rx_load    = upd_rise & (~rx_valid_o | rx_ready_i);
  assign rx_drop    = upd_rise & ~rx_load;
  assign tx_ready_o = ~tx_full;
  assign jtag_tdo_o = sr[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr         <= '0;
      tx_hold    <= '0;
      tx_full    <= 1'b0;
      rx_data_o  <= '0;
      rx_addr_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      if (s_reset) begin
        sr <= '0;
      end else if (cap_fire) begin
        sr <= cap_word;
      end else if (tck_rise && s_shift) begin
        sr <= {s_tdi, sr[W-1:1]};
      end

      // A push landing with capture still loads; the capture already saw the old contents.
      if (tx_push) begin
        tx_hold <= tx_data_i;
        tx_full <= 1'b1;
      end else if (cap_fire) begin
        tx_full <= 1'b0;
      end

      if (rx_load) begin
        {rx_addr_o, rx_data_o} <= sr;
        rx_valid_o             <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      if (s_reset) begin
        overrun_o <= 1'b0;
      end else if (rx_drop) begin
        overrun_o <= 1'b1;
      end
    end
  end

`ifdef JTAG_DR_OVERRUN_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || s_reset) begin
      overrun_cnt_o <= 8'd0;
    end else if (rx_drop && overrun_cnt_o != 8'hFF) begin
      overrun_cnt_o <= overrun_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_dr_engine.sv
// Directed bench for jtag_dr_engine: TAP model with tck = clk/12, checked by immediate assertions.
module tb_jtag_dr_engine;

  logic       clk = 1'b0;
  logic       rst, tck, tdi, tdo, capture, shift, update, jreset;
  logic [7:0] rx_data, tx_data;
  logic [2:0] rx_addr;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, overrun;
`ifdef JTAG_DR_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [10:0] bits;

  always #5 clk = ~clk;

  jtag_dr_engine #(.DATA_W(8), .ADDR_W(3), .SYNC_STAGES(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .jtag_tck_i     (tck),
    .jtag_tdi_i     (tdi),
    .jtag_tdo_o     (tdo),
    .jtag_capture_i (capture),
    .jtag_shift_i   (shift),
    .jtag_update_i  (update),
    .jtag_reset_i   (jreset),
    .rx_data_o      (rx_data),
    .rx_addr_o      (rx_addr),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .overrun_o      (overrun)
`ifdef JTAG_DR_OVERRUN_CNT_EN
    , .overrun_cnt_o (overrun_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits of v LSB first; TDO is sampled just before each TCK rise.
  task automatic scan(input logic [10:0] v, input int n, output logic [10:0] out);
    out   = '0;
    shift = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi = v[i];
      tick(6);
      out[i] = tdo;
      tck = 1'b1;
      tick(6);
      tck = 1'b0;
    end
    shift = 1'b0;
    tdi   = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1;
    tick(6);
    update = 1'b0;
    tick(6);
  endtask

  initial begin
    rst = 1'b1; tck = 1'b0; tdi = 1'b0; capture = 1'b0; shift = 1'b0;
    update = 1'b0; jreset = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(4);
    rst = 1'b0;
    tick(2);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_addr", rx_addr, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_tdo", tdo, 0);
`ifdef JTAG_DR_OVERRUN_CNT_EN
    chk("rst_cnt", overrun_cnt, 0);
`endif

    // Host write and update latency
    scan(11'b101_1010_0101, 11, bits);
    update = 1'b1;
    tick(3);
    chk("upd_lat_early", rx_valid, 0);
    tick(1);
    chk("upd_lat_valid", rx_valid, 1);
    chk("t1_addr", rx_addr, 3'b101);
    chk("t1_data", rx_data, 8'hA5);
    tick(2);
    update = 1'b0;
    tick(6);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("t1_pop", rx_valid, 0);

    // CPU word returned through capture
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    chk("t2_tx_full", tx_ready, 0);
    capture = 1'b1;
    tick(6);
    tck = 1'b1;
    tick(3);
    chk("t2_cap_early", tx_ready, 0);
    tick(1);
    chk("t2_cap_done", tx_ready, 1);
    tick(2);
    tck = 1'b0;
    capture = 1'b0;
    scan(11'd0, 11, bits);
    chk("t2_tdo_data", bits[7:0], 8'h3C);
    chk("t2_tdo_rxfull", bits[8], 0);
    chk("t2_tdo_txfull", bits[9], 1);
    chk("t2_tdo_msb", bits[10], 0);

    // Overrun: second update while rx is full and not popped
    scan({3'b001, 8'h11}, 11, bits);
    do_update();
    chk("t3_first", rx_valid, 1);
    scan({3'b010, 8'h23}, 11, bits);
    do_update();
    chk("t3_overrun", overrun, 1);
    chk("t3_held_data", rx_data, 8'h11);
    chk("t3_held_addr", rx_addr, 3'b001);
    chk("t3_tdo_sr", tdo, 1);
`ifdef JTAG_DR_OVERRUN_CNT_EN
    chk("t3_cnt1", overrun_cnt, 1);
    repeat (299) do_update();
    chk("t3_cnt_sat", overrun_cnt, 255);
`endif

    // TAP reset clears sr and overrun, keeps rx holding
    jreset = 1'b1;
    tick(6);
    jreset = 1'b0;
    tick(6);
    chk("t6_overrun", overrun, 0);
    chk("t6_tdo", tdo, 0);
    chk("t6_rx_valid", rx_valid, 1);
    chk("t6_rx_data", rx_data, 8'h11);
`ifdef JTAG_DR_OVERRUN_CNT_EN
    chk("t6_cnt", overrun_cnt, 0);
`endif
    scan(11'd0, 11, bits);
    chk("t6_sr_zero", bits, 0);

    // Pop coincident with update: new word replaces old, valid stays high
    scan({3'b010, 8'h55}, 11, bits);
    update = 1'b1;
    tick(3);
    chk("t4_pre", rx_valid, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("t4_valid", rx_valid, 1);
    chk("t4_data", rx_data, 8'h55);
    chk("t4_addr", rx_addr, 3'b010);
    chk("t4_overrun", overrun, 0);
    tick(2);
    update = 1'b0;
    tick(6);

    // System reset mid-scan, then a clean scan
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("t5_pop", rx_valid, 0);
    scan(11'h7FF, 5, bits);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("t5_rst_valid", rx_valid, 0);
    chk("t5_rst_tdo", tdo, 0);
    chk("t5_rst_txrdy", tx_ready, 1);
    scan({3'b011, 8'hC3}, 11, bits);
    do_update();
    chk("t5_valid", rx_valid, 1);
    chk("t5_data", rx_data, 8'hC3);
    chk("t5_addr", rx_addr, 3'b011);
    chk("t5_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
